calc_cmd_driver: RTL and testbench

//  Host-side initiator for the calculator core. Accepts one command (mode, float operand, n) on a

---
 rtl/calc_pkg.sv | 23 ++
 rtl/calc_drv_timer.sv | 28 ++
 rtl/calc_cmd_driver.sv | 166 ++++++++++++++++
 tb/tb_calc_cmd_driver.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared encodings and widths for the calculator command driver.
// Holds the driver FSM states, the core's idle encoding and the mode codes.
package calc_pkg;

    localparam int unsigned MODE_W  = 3;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STATE_W = 9;
    localparam int unsigned TIMER_W = 11;
    localparam int unsigned CYC_W   = 16;

    localparam logic [STATE_W-1:0] CALC_IDLE_STATE = 9'h001;

    localparam logic [MODE_W-1:0] MODE_EXP = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESP
    } drv_state_t;

endpackage

// File: rtl/calc_drv_timer.sv
// calc_drv_timer: clear/enable saturating cycle counter with a terminal-count flag.
// o_tc is high during the i_limit-th counted cycle, so a transition on it lands after exactly i_limit cycles.
module calc_drv_timer #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count >= (i_limit - 1'b1));

endmodule

// File: rtl/calc_cmd_driver.sv
// calc_cmd_driver: accepts one command, launches the calculator core, waits for completion and returns the result.
// Define CALC_DRV_CYCLE_COUNT_EN to add the rsp_cycles accept-to-response latency output.
module calc_cmd_driver
    import calc_pkg::*;
#(
    parameter int unsigned        START_CYCLES   = 2,
    parameter logic [STATE_W-1:0] IDLE_STATE     = CALC_IDLE_STATE,
    parameter int unsigned        TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [MODE_W-1:0]  cmd_mode,
    input  logic [DATA_W-1:0]  cmd_x,
    input  logic [DATA_W-1:0]  cmd_n,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_timeout,
    output logic               busy,
    output logic               calc_start,
    output logic [MODE_W-1:0]  calc_mode,
    output logic [DATA_W-1:0]  calc_input,
    output logic [DATA_W-1:0]  calc_n,
    input  logic [DATA_W-1:0]  calc_acc,
    input  logic [STATE_W-1:0] calc_state
`ifdef CALC_DRV_CYCLE_COUNT_EN
    ,
    output logic [CYC_W-1:0]   rsp_cycles
`endif
);

    drv_state_t         r_state;
    drv_state_t         w_next;
    logic               w_accept;
    logic               w_capture;
    logic               w_cap_timeout;
    logic               w_cap_zero;
    logic               w_tmr_clear;
    logic               w_tmr_en;
    logic               w_tmr_tc;
    logic [TIMER_W-1:0] w_tmr_limit;

    logic [MODE_W-1:0]  r_calc_mode;
    logic [DATA_W-1:0]  r_calc_input;
    logic [DATA_W-1:0]  r_calc_n;
    logic [DATA_W-1:0]  r_rsp_result;
    logic               r_rsp_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        w_cap_timeout = 1'b0;
        w_cap_zero    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (w_tmr_tc) w_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (calc_state != IDLE_STATE) begin
                    w_next = ST_WAIT_DONE;
                end else if (w_tmr_tc) begin
                    w_next        = ST_RESP;
                    w_capture     = 1'b1;
                    w_cap_timeout = 1'b1;
                    w_cap_zero    = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (calc_state == IDLE_STATE) begin
                    w_next    = ST_RESP;
                    w_capture = 1'b1;
                end else if (w_tmr_tc) begin
                    w_next        = ST_RESP;
                    w_capture     = 1'b1;
                    w_cap_timeout = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // One timer serves both the start pulse and the timeout: it restarts on every state change.
    assign w_tmr_clear = (w_next != r_state) || (r_state == ST_IDLE);
    assign w_tmr_en    = (r_state inside {ST_LAUNCH, ST_WAIT_BUSY, ST_WAIT_DONE});
    assign w_tmr_limit = (r_state == ST_LAUNCH) ? TIMER_W'(START_CYCLES) : TIMER_W'(TIMEOUT_CYCLES);

    calc_drv_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clear (w_tmr_clear),
        .i_en    (w_tmr_en),
        .i_limit (w_tmr_limit),
        .o_tc    (w_tmr_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_calc_mode   <= '0;
            r_calc_input  <= '0;
            r_calc_n      <= '0;
            r_rsp_result  <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_calc_mode  <= cmd_mode;
                r_calc_input <= cmd_x;
                r_calc_n     <= cmd_n;
            end
            if (w_capture) begin
                r_rsp_result  <= w_cap_zero ? '0 : calc_acc;
                r_rsp_timeout <= w_cap_timeout;
            end
        end
    end

`ifdef CALC_DRV_CYCLE_COUNT_EN
    logic [CYC_W-1:0] r_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycles <= '0;
        end else if (w_accept) begin
            r_cycles <= '0;
        end else if (w_tmr_en && (r_cycles != '1)) begin
            r_cycles <= r_cycles + 1'b1;
        end
    end

    assign rsp_cycles = r_cycles;
`else
    // No latency counter in this build.
`endif

    assign cmd_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign rsp_valid   = (r_state == ST_RESP);
    assign calc_start  = (r_state == ST_LAUNCH);
    assign calc_mode   = r_calc_mode;
    assign calc_input  = r_calc_input;
    assign calc_n      = r_calc_n;
    assign rsp_result  = r_rsp_result;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_calc_cmd_driver.sv
// tb_calc_cmd_driver: scoreboard bench for calc_cmd_driver with a behavioural calculator core model.
// Honours CALC_DRV_CYCLE_COUNT_EN to connect and check rsp_cycles.
module tb_calc_cmd_driver;
    import calc_pkg::*;

    localparam logic [8:0] BUSY_ST = 9'h040;
    localparam logic [31:0] PARTIAL_ACC = 32'h0000_1111;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_mode;
    logic [31:0] cmd_x;
    logic [31:0] cmd_n;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_timeout;
    logic        busy;
    logic        calc_start;
    logic [2:0]  calc_mode;
    logic [31:0] calc_input;
    logic [31:0] calc_n;
    logic [31:0] calc_acc;
    logic [8:0]  calc_state;
`ifdef CALC_DRV_CYCLE_COUNT_EN
    logic [15:0] rsp_cycles;
`endif

    always #5 clk = ~clk;

    calc_cmd_driver #(
        .START_CYCLES   (2),
        .IDLE_STATE     (9'h001),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode    (cmd_mode),
        .cmd_x       (cmd_x),
        .cmd_n       (cmd_n),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .calc_start  (calc_start),
        .calc_mode   (calc_mode),
        .calc_input  (calc_input),
        .calc_n      (calc_n),
        .calc_acc    (calc_acc),
        .calc_state  (calc_state)
`ifdef CALC_DRV_CYCLE_COUNT_EN
        ,
        .rsp_cycles  (rsp_cycles)
`endif
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    int unsigned start_hi = 0;

    typedef struct {
        logic [31:0] result;
        logic        timeout;
        int unsigned latency;
    } exp_t;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (calc_start === 1'b1) start_hi <= start_hi + 1;

    // Core model: goes busy on the edge after calc_start falls, busy for model_delay cycles.
    typedef enum int {M_NORMAL, M_NEVER, M_FOREVER} mmode_t;
    mmode_t      model_mode = M_NORMAL;
    int unsigned model_delay = 40;
    logic [31:0] model_acc = '0;
    logic        m_busy;
    logic        m_prev_start;
    int unsigned m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy       <= 1'b0;
            m_prev_start <= 1'b0;
            m_cnt        <= 0;
            calc_acc     <= '0;
        end else begin
            m_prev_start <= calc_start;
            if (model_mode == M_NEVER) begin
                m_busy <= 1'b0;
            end else if (m_busy) begin
                if (model_mode == M_NORMAL) begin
                    if (m_cnt <= 1) begin
                        m_busy   <= 1'b0;
                        calc_acc <= model_acc;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
            end else if (m_prev_start && !calc_start) begin
                m_busy   <= 1'b1;
                m_cnt    <= model_delay;
                calc_acc <= PARTIAL_ACC;
            end
        end
    end

    assign calc_state = m_busy ? BUSY_ST : CALC_IDLE_STATE;

    task automatic send_cmd(input logic [2:0] m, input logic [31:0] x, input logic [31:0] n,
                            output int unsigned acc_cyc, output bit ok);
        ok = 1'b0;
        acc_cyc = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_x     = x;
        cmd_n     = n;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int unsigned limit, output int unsigned at_cyc, output bit ok);
        ok = 1'b0;
        at_cyc = 0;
        for (int unsigned i = 0; i < limit; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode = '0;
        cmd_x = '0;
        cmd_n = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({cmd_ready, busy, calc_start, rsp_valid, rsp_timeout} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 10000", {cmd_ready, busy, calc_start, rsp_valid, rsp_timeout});
        end
        total++;
        if ({calc_mode, calc_input, calc_n, rsp_result} !== 99'd0) begin
            bad++;
            $display("FAIL reset_data: mode=%h in=%h n=%h res=%h want all 0", calc_mode, calc_input, calc_n, rsp_result);
        end
`ifdef CALC_DRV_CYCLE_COUNT_EN
        total++;
        if (rsp_cycles !== 16'd0) begin
            bad++;
            $display("FAIL reset_cycles: got %0d want 0", rsp_cycles);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_exp();
        int unsigned a, r, s0;
        bit ok;
        exp_t e;
        model_mode = M_NORMAL;
        model_delay = 40;
        model_acc = 32'h3f9c4d1a;
        s0 = start_hi;
        send_cmd(MODE_EXP, 32'h3e4ccccd, 32'd5, a, ok);
        sb.push_back('{32'h3f9c4d1a, 1'b0, 44});
        total++;
        if (!ok || {calc_mode, calc_input, calc_n} !== {MODE_EXP, 32'h3e4ccccd, 32'd5}) begin
            bad++;
            $display("FAIL exp_operands: ok=%0d mode=%h in=%h n=%h", ok, calc_mode, calc_input, calc_n);
        end
        wait_rsp(200, r, ok);
        e = sb.pop_front();
        total++;
        if (!ok || {rsp_result, rsp_timeout} !== {e.result, e.timeout}) begin
            bad++;
            $display("FAIL exp_result: ok=%0d got %h/%b want %h/%b", ok, rsp_result, rsp_timeout, e.result, e.timeout);
        end
        total++;
        if (r - a !== e.latency) begin
            bad++;
            $display("FAIL exp_latency: got %0d want %0d", r - a, e.latency);
        end
        total++;
        if (start_hi - s0 !== 2) begin
            bad++;
            $display("FAIL exp_start_len: got %0d want 2", start_hi - s0);
        end
`ifdef CALC_DRV_CYCLE_COUNT_EN
        total++;
        if (rsp_cycles !== 16'd44) begin
            bad++;
            $display("FAIL exp_rsp_cycles: got %0d want 44", rsp_cycles);
        end
`endif
        handshake();
        total++;
        if ({cmd_ready, rsp_valid, calc_mode, calc_n} !== {1'b1, 1'b0, MODE_EXP, 32'd5}) begin
            bad++;
            $display("FAIL exp_after: rdy=%b vld=%b mode=%h n=%h want 1 0 5 5", cmd_ready, rsp_valid, calc_mode, calc_n);
        end
    endtask

    task automatic test_timeout_never();
        int unsigned a, r;
        bit ok;
        exp_t e;
        model_mode = M_NEVER;
        send_cmd(3'b001, 32'h1, 32'h2, a, ok);
        sb.push_back('{32'h0, 1'b1, 1026});
        wait_rsp(1200, r, ok);
        e = sb.pop_front();
        total++;
        if (!ok || {rsp_result, rsp_timeout} !== {e.result, e.timeout}) begin
            bad++;
            $display("FAIL never_result: ok=%0d got %h/%b want %h/%b", ok, rsp_result, rsp_timeout, e.result, e.timeout);
        end
        total++;
        if (r - a !== e.latency) begin
            bad++;
            $display("FAIL never_latency: got %0d want %0d", r - a, e.latency);
        end
        handshake();
    endtask

    task automatic test_timeout_forever();
        int unsigned a, r;
        bit ok;
        exp_t e;
        model_mode = M_FOREVER;
        send_cmd(3'b011, 32'h55, 32'h7, a, ok);
        sb.push_back('{PARTIAL_ACC, 1'b1, 1028});
        wait_rsp(1200, r, ok);
        e = sb.pop_front();
        total++;
        if (!ok || {rsp_result, rsp_timeout} !== {e.result, e.timeout}) begin
            bad++;
            $display("FAIL forever_result: ok=%0d got %h/%b want %h/%b", ok, rsp_result, rsp_timeout, e.result, e.timeout);
        end
        total++;
        if (r - a !== e.latency) begin
            bad++;
            $display("FAIL forever_latency: got %0d want %0d", r - a, e.latency);
        end
        handshake();
        model_mode = M_NEVER;
        repeat (2) @(negedge clk);
        model_mode = M_NORMAL;
        model_delay = 3;
        model_acc = 32'hA5A5_0001;
        send_cmd(3'b010, 32'h99, 32'h3, a, ok);
        sb.push_back('{32'hA5A5_0001, 1'b0, 7});
        wait_rsp(100, r, ok);
        e = sb.pop_front();
        total++;
        if (!ok || {rsp_result, rsp_timeout, r - a} !== {e.result, e.timeout, e.latency}) begin
            bad++;
            $display("FAIL forever_next: ok=%0d got %h/%b/%0d want %h/%b/%0d", ok, rsp_result, rsp_timeout, r - a, e.result, e.timeout, e.latency);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int unsigned a, r;
        bit ok;
        exp_t e;
        model_mode = M_NORMAL;
        model_delay = 3;
        model_acc = 32'h1234_5678;
        send_cmd(3'b001, 32'h1, 32'h2, a, ok);
        sb.push_back('{32'h1234_5678, 1'b0, 7});
        wait_rsp(100, r, ok);
        e = sb.pop_front();
        total++;
        if (!ok || {rsp_result, rsp_timeout, r - a} !== {e.result, e.timeout, e.latency}) begin
            bad++;
            $display("FAIL bp_first: ok=%0d got %h/%b/%0d want %h/%b/%0d", ok, rsp_result, rsp_timeout, r - a, e.result, e.timeout, e.latency);
        end
        model_acc = 32'hFFFF_0000;
        cmd_valid = 1'b1;
        cmd_mode  = 3'b110;
        cmd_x     = 32'hCAFE;
        cmd_n     = 32'd9;
        for (int i = 0; i < 20; i++) begin
            total++;
            if ({rsp_valid, cmd_ready, rsp_result, calc_mode} !== {1'b1, 1'b0, e.result, 3'b001}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b res=%h mode=%h want 1 0 %h 1", i, rsp_valid, cmd_ready, rsp_result, calc_mode, e.result);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready_after: got %b want 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        a = cyc;
        cmd_valid = 1'b0;
        model_acc = 32'h0BEE_F00D;
        sb.push_back('{32'h0BEE_F00D, 1'b0, 7});
        total++;
        if ({busy, calc_mode, calc_input, calc_n} !== {1'b1, 3'b110, 32'hCAFE, 32'd9}) begin
            bad++;
            $display("FAIL bp_accept2: busy=%b mode=%h in=%h n=%h want 1 6 cafe 9", busy, calc_mode, calc_input, calc_n);
        end
        wait_rsp(100, r, ok);
        e = sb.pop_front();
        total++;
        if (!ok || {rsp_result, rsp_timeout, r - a} !== {e.result, e.timeout, e.latency}) begin
            bad++;
            $display("FAIL bp_second: ok=%0d got %h/%b/%0d want %h/%b/%0d", ok, rsp_result, rsp_timeout, r - a, e.result, e.timeout, e.latency);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int unsigned a, r;
        bit ok;
        exp_t e;
        model_mode = M_NORMAL;
        model_delay = 40;
        model_acc = 32'h0000_0077;
        send_cmd(3'b100, 32'h10, 32'h20, a, ok);
        sb.push_back('{32'h0000_0077, 1'b0, 44});
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({calc_start, busy, rsp_valid, cmd_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL midreset_outputs: start=%b busy=%b vld=%b rdy=%b want 0 0 0 1", calc_start, busy, rsp_valid, cmd_ready);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        model_delay = 2;
        model_acc = 32'h0BAD_F00D;
        send_cmd(3'b111, 32'h3, 32'h4, a, ok);
        sb.push_back('{32'h0BAD_F00D, 1'b0, 6});
        wait_rsp(100, r, ok);
        e = sb.pop_front();
        total++;
        if (!ok || {rsp_result, rsp_timeout, r - a} !== {e.result, e.timeout, e.latency}) begin
            bad++;
            $display("FAIL midreset_next: ok=%0d got %h/%b/%0d want %h/%b/%0d", ok, rsp_result, rsp_timeout, r - a, e.result, e.timeout, e.latency);
        end
`ifdef CALC_DRV_CYCLE_COUNT_EN
        total++;
        if (rsp_cycles !== 16'd6) begin
            bad++;
            $display("FAIL midreset_cycles: got %0d want 6", rsp_cycles);
        end
`endif
        handshake();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_exp();
        test_timeout_never();
        test_timeout_forever();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
